fsm16bit_monitor: RTL and testbench
===================================

Name: fsm16bit_monitor

Overview:
- Passive checker on the far side of the fsm16bit control/count interface.
- Samples the same enable/check/mode/direction/value stimulus the 16-bit FSM receives and keeps a cycle-accurate reference copy of its state.
- Compares that copy against the FSM's count output every cycle.
- Reports per-cycle mismatches, a sticky fault, a saturating error count and a capture of the first bad sample, for on-board debug (LEDs/7-seg) and for simulation.

Parameters:
- STUDENT_ID, 16'h3782: value loaded when check==0; must equal the FSM's load constant.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clock  in  1  system clock; the FSM under observation uses the same clock.
- reset  in  1  monitor reset; one clock; reset is synchronous and active-high.
- dut_reset_n  in  1  FSM's active-low reset, sampled synchronously here.
- enable  in  1  FSM enable, as driven to the FSM.
- check  in  1  0 = load STUDENT_ID.
- mode  in  1  0 = rotate, 1 = add/subtract.
- direction  in  1  rotate: 0 right / 1 left; arith: 0 subtract / 1 add.
- value  in  4  arithmetic operand, zero-extended.
- count  in  16  observed FSM state.
- clear  in  1  resync and clear fault/captures.
- synced  out  1  reference model valid; comparisons active.
- mismatch  out  1  registered one-cycle pulse per detected mismatch.
- fault  out  1  sticky; set on first mismatch.
- err_count  out  ERR_W  saturating mismatch count.
- bad_expected  out  16  reference value at first mismatch.
- bad_actual  out  16  count value at first mismatch.

Behaviour:
- Reset (reset==1 at a clock edge): state=UNSYNC, expected=0, all outputs 0. Reset has priority over all other inputs.
- Reference update at every edge, priority order:
  - dut_reset_n==0 -> expected=0.
  - else enable==1:
    - check==0 -> expected=STUDENT_ID.
    - mode==0, direction==0 -> rotate right {e[0],e[15:1]}.
    - mode==0, direction==1 -> rotate left {e[14:0],e[15]}.
    - mode==1, direction==0 -> e-value; direction==1 -> e+value. Modulo 2^16, wrap silent.
  - else hold.
- Comparison at each edge, using pre-update count vs expected. Registered result, so a wrong FSM update made at edge k is flagged as mismatch during the cycle after edge k+1. Latency 1.
- Comparison suppressed when state==UNSYNC, when dut_reset_n==0 at this edge, and for the one edge after dut_reset_n returns high. The async FSM reset may clear count between edges.
- States:
  - UNSYNC: synced=0. Exits to TRACK at the edge where dut_reset_n==0, or where enable&&!check is sampled.
  - TRACK: synced=1. A mismatch -> FAULT.
  - FAULT: synced=1, fault=1. Continues comparing, pulsing mismatch and counting.
  - Any state with clear==1 (and reset==0) -> TRACK with expected<=count, fault/err_count/bad_* cleared, mismatch=0. clear outranks a same-cycle mismatch and a same-cycle dut_reset_n low (expected<=0 in that case).
- Mismatch bookkeeping:
  - err_count increments per mismatch and saturates at 2^ERR_W-1.
  - bad_expected/bad_actual load only on the mismatch that sets fault; later mismatches do not overwrite them.
- dut_reset_n low while in FAULT: expected=0, fault stays set; only clear or reset clears it.

Decomposition:
- Package fsm16bit_pkg:
  - STUDENT_ID constant.
  - Monitor state enum (UNSYNC, TRACK, FAULT).
  - Op decode constants (LOAD, ROR, ROL, SUB, ADD).
  - Pure function next_state(cur,check,mode,direction,value), shared with future benches.
- One sub-module is natural: fsm16bit_ref_model, a combinational next-state block instanced by the monitor.
- Sequencing, compare and bookkeeping stay in the top.

Test Plan:
- Reset, then dut_reset_n pulse low, then enable/check=0 with count=16'h3782 -> synced=1, no mismatch, fault=0.
- From 16'h3782: rotate right (count=16'h1BC1), then rotate left twice (count=16'h3782, then 16'h6F04) -> no mismatch.
- From 0: subtract value=1 (count=16'hFFFF), then add value=4'hF (count=16'h000E) -> wrap accepted, no mismatch.
- From 16'h3782, rotate right with count forced to 16'h1BC0 -> mismatch pulse one cycle after the bad sample, fault=1, err_count=1, bad_expected=16'h1BC1, bad_actual=16'h1BC0.
- Hold count wrong for 300 cycles with ERR_W=8 -> err_count saturates at 255 and bad_* remain from the first mismatch. Then clear -> TRACK, expected=count, err_count=0.
- Assert dut_reset_n low mid-arithmetic with count dropping asynchronously -> no mismatch during suppression. Assert reset mid-FAULT -> all outputs 0, state UNSYNC.

Source files
------------

// File: rtl/fsm16bit_pkg.sv
// Shared definitions for the 16-bit FSM and its monitor: load constant,
// monitor states, op decode and the FSM's pure next-state function.
package fsm16bit_pkg;

    localparam logic [15:0] STUDENT_ID = 16'h3782;

    typedef enum logic [1:0] {
        UNSYNC = 2'd0,
        TRACK  = 2'd1,
        FAULT  = 2'd2
    } mon_state_t;

    typedef enum logic [2:0] {
        OP_LOAD = 3'd0,
        OP_ROR  = 3'd1,
        OP_ROL  = 3'd2,
        OP_SUB  = 3'd3,
        OP_ADD  = 3'd4
    } op_t;

    function automatic op_t decode_op(input logic check, input logic mode,
                                      input logic direction);
        op_t op;
        if (!check)         op = OP_LOAD;
        else if (!mode)     op = direction ? OP_ROL : OP_ROR;
        else                op = direction ? OP_ADD : OP_SUB;
        return op;
    endfunction

    // Arithmetic wraps modulo 2^16 with no flag, exactly as the FSM does.
    function automatic logic [15:0] next_state(input logic [15:0] cur,
                                               input logic check,
                                               input logic mode,
                                               input logic direction,
                                               input logic [3:0] value);
        logic [15:0] nxt;
        case (decode_op(check, mode, direction))
            OP_LOAD: nxt = STUDENT_ID;
            OP_ROR:  nxt = {cur[0], cur[15:1]};
            OP_ROL:  nxt = {cur[14:0], cur[15]};
            OP_SUB:  nxt = cur - {12'd0, value};
            default: nxt = cur + {12'd0, value};
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/fsm16bit_monitor_if.sv
// Stimulus and observed-count bus shared by the 16-bit FSM and its monitor.
interface fsm16bit_monitor_if;

    logic        dut_reset_n;
    logic        enable;
    logic        check;
    logic        mode;
    logic        direction;
    logic [3:0]  value;
    logic [15:0] count;

    modport master (output dut_reset_n, enable, check, mode, direction, value, count);
    modport slave  (input  dut_reset_n, enable, check, mode, direction, value, count);

endinterface

// File: rtl/fsm16bit_ref_model.sv
// Combinational reference of the FSM's next state for one clock edge.
module fsm16bit_ref_model #(
    parameter logic [15:0] STUDENT_ID = fsm16bit_pkg::STUDENT_ID
) (
    input  logic [15:0] cur,
    input  logic        dut_reset_n,
    input  logic        enable,
    input  logic        check,
    input  logic        mode,
    input  logic        direction,
    input  logic [3:0]  value,
    output logic [15:0] nxt
);
    import fsm16bit_pkg::*;

    // The load branch uses the local parameter so an overridden ID is honoured.
    always_comb begin
        nxt = cur;
        if (!dut_reset_n)
            nxt = '0;
        else if (enable)
            nxt = check ? next_state(cur, check, mode, direction, value) : STUDENT_ID;
    end

endmodule

// File: rtl/fsm16bit_monitor.sv
// Passive monitor: tracks a reference copy of the 16-bit FSM state and flags,
// counts and captures any divergence of the observed count.
module fsm16bit_monitor #(
    parameter logic [15:0] STUDENT_ID = fsm16bit_pkg::STUDENT_ID,
    parameter int          ERR_W      = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    fsm16bit_monitor_if.slave    bus,
    input  logic                 clear,
    output logic                 synced,
    output logic                 mismatch,
    output logic                 fault,
    output logic [ERR_W-1:0]     err_count,
    output logic [15:0]          bad_expected,
    output logic [15:0]          bad_actual
);
    import fsm16bit_pkg::*;

    mon_state_t  state, state_nxt;
    logic [15:0] expected;
    logic [15:0] ref_nxt;
    logic        dut_rstn_p0;
    logic        cmp_en;
    logic        hit;

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    fsm16bit_ref_model #(.STUDENT_ID(STUDENT_ID)) u_ref (
        .cur         (expected),
        .dut_reset_n (bus.dut_reset_n),
        .enable      (bus.enable),
        .check       (bus.check),
        .mode        (bus.mode),
        .direction   (bus.direction),
        .value       (bus.value),
        .nxt         (ref_nxt)
    );

    // Skip the first edge after FSM reset release: its asynchronous reset
    // timing relative to our clock is unknown.
    assign cmp_en = (state != UNSYNC) && bus.dut_reset_n && dut_rstn_p0;
    assign hit    = cmp_en && (bus.count != expected);

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = TRACK;
        end else begin
            case (state)
                UNSYNC:  if (!bus.dut_reset_n || (bus.enable && !bus.check)) state_nxt = TRACK;
                TRACK:   if (hit) state_nxt = FAULT;
                FAULT:   state_nxt = FAULT;
                default: state_nxt = UNSYNC;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= UNSYNC;
            expected     <= '0;
            dut_rstn_p0  <= 1'b0;
            mismatch     <= 1'b0;
            err_count    <= '0;
            bad_expected <= '0;
            bad_actual   <= '0;
        end else begin
            state       <= state_nxt;
            dut_rstn_p0 <= bus.dut_reset_n;
            if (clear) begin
                expected     <= bus.dut_reset_n ? bus.count : 16'h0000;
                mismatch     <= 1'b0;
                err_count    <= '0;
                bad_expected <= '0;
                bad_actual   <= '0;
            end else begin
                expected <= ref_nxt;
                mismatch <= hit;
                if (hit)
                    err_count <= sat_inc(err_count);
                if (hit && (state == TRACK)) begin
                    bad_expected <= expected;
                    bad_actual   <= bus.count;
                end
            end
        end
    end

    assign synced = (state != UNSYNC);
    assign fault  = (state == FAULT);

endmodule

// File: tb/tb_fsm16bit_monitor.sv
// Scoreboard bench for fsm16bit_monitor: the bench plays the FSM by driving
// count directly and queues the monitor outputs expected after each edge.
module tb_fsm16bit_monitor;

    localparam int ERR_W = 8;

    typedef struct packed {
        logic        rst;
        logic        clr;
        logic        rstn;
        logic        en;
        logic        chk;
        logic        md;
        logic        dir;
        logic [3:0]  val;
        logic [15:0] cnt;
    } stim_t;

    typedef logic [42:0] obs_t;

    logic             clock = 1'b0;
    logic             reset;
    logic             clear;
    logic             synced;
    logic             mismatch;
    logic             fault;
    logic [ERR_W-1:0] err_count;
    logic [15:0]      bad_expected;
    logic [15:0]      bad_actual;

    obs_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    fsm16bit_monitor_if bus();

    fsm16bit_monitor #(.STUDENT_ID(16'h3782), .ERR_W(ERR_W)) dut (
        .clock        (clock),
        .reset        (reset),
        .bus          (bus.slave),
        .clear        (clear),
        .synced       (synced),
        .mismatch     (mismatch),
        .fault        (fault),
        .err_count    (err_count),
        .bad_expected (bad_expected),
        .bad_actual   (bad_actual)
    );

    always #5 clock = ~clock;

    function automatic obs_t mk(input logic s, input logic m, input logic f,
                                input logic [7:0] e, input logic [15:0] be,
                                input logic [15:0] ba);
        return {s, m, f, e, be, ba};
    endfunction

    function automatic stim_t S(input logic rst, input logic clr, input logic rstn,
                                input logic en, input logic chk, input logic md,
                                input logic dir, input logic [3:0] val,
                                input logic [15:0] cnt);
        stim_t s;
        s = '{rst, clr, rstn, en, chk, md, dir, val, cnt};
        return s;
    endfunction

    function automatic stim_t HOLD(input logic [15:0] c); return S(0,0,1,0,1,0,0,4'h0,c); endfunction
    function automatic stim_t LOAD(input logic [15:0] c); return S(0,0,1,1,0,0,0,4'h0,c); endfunction
    function automatic stim_t ROR (input logic [15:0] c); return S(0,0,1,1,1,0,0,4'h0,c); endfunction
    function automatic stim_t ROL (input logic [15:0] c); return S(0,0,1,1,1,0,1,4'h0,c); endfunction
    function automatic stim_t SUB (input logic [3:0] v, input logic [15:0] c); return S(0,0,1,1,1,1,0,v,c); endfunction
    function automatic stim_t ADD (input logic [3:0] v, input logic [15:0] c); return S(0,0,1,1,1,1,1,v,c); endfunction
    function automatic stim_t DRST(input logic [15:0] c); return S(0,0,0,1,1,1,1,4'h3,c); endfunction

    function automatic obs_t CLEAN(); return mk(1,0,0,8'd0,16'h0,16'h0); endfunction
    function automatic obs_t IDLE();  return mk(0,0,0,8'd0,16'h0,16'h0); endfunction

    task automatic apply(input stim_t s, input obs_t exp);
        reset           = s.rst;
        clear           = s.clr;
        bus.dut_reset_n = s.rstn;
        bus.enable      = s.en;
        bus.check       = s.chk;
        bus.mode        = s.md;
        bus.direction   = s.dir;
        bus.value       = s.val;
        bus.count       = s.cnt;
        sb.push_back(exp);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        stim_t st[$]; obs_t ex[$]; obs_t want; obs_t got;
        st.push_back(S(1,1,0,1,0,1,1,4'hF,16'hFFFF)); ex.push_back(IDLE());
        st.push_back(S(1,0,1,1,1,0,0,4'h1,16'h1234)); ex.push_back(IDLE());
        st.push_back(HOLD(16'h1234));                 ex.push_back(IDLE());
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            want = sb.pop_front();
            got  = {synced, mismatch, fault, err_count, bad_expected, bad_actual};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset[%0d]: observed %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_load();
        stim_t st[$]; obs_t ex[$]; obs_t want; obs_t got;
        st.push_back(S(0,0,0,0,1,0,0,4'h0,16'h0000)); ex.push_back(CLEAN());
        st.push_back(LOAD(16'h0000));                 ex.push_back(CLEAN());
        st.push_back(HOLD(16'h3782));                 ex.push_back(CLEAN());
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            want = sb.pop_front();
            got  = {synced, mismatch, fault, err_count, bad_expected, bad_actual};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL load[%0d]: observed %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_rotate();
        stim_t st[$]; obs_t ex[$]; obs_t want; obs_t got;
        st.push_back(ROR(16'h3782));  ex.push_back(CLEAN());
        st.push_back(ROL(16'h1BC1));  ex.push_back(CLEAN());
        st.push_back(ROL(16'h3782));  ex.push_back(CLEAN());
        st.push_back(HOLD(16'h6F04)); ex.push_back(CLEAN());
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            want = sb.pop_front();
            got  = {synced, mismatch, fault, err_count, bad_expected, bad_actual};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL rotate[%0d]: observed %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_arith_wrap();
        stim_t st[$]; obs_t ex[$]; obs_t want; obs_t got;
        st.push_back(DRST(16'h0000));        ex.push_back(CLEAN());
        st.push_back(HOLD(16'h0000));        ex.push_back(CLEAN());
        st.push_back(SUB(4'h1, 16'h0000));   ex.push_back(CLEAN());
        st.push_back(ADD(4'hF, 16'hFFFF));   ex.push_back(CLEAN());
        st.push_back(HOLD(16'h000E));        ex.push_back(CLEAN());
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            want = sb.pop_front();
            got  = {synced, mismatch, fault, err_count, bad_expected, bad_actual};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL arith[%0d]: observed %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_mismatch();
        stim_t st[$]; obs_t ex[$]; obs_t want; obs_t got;
        st.push_back(LOAD(16'h000E)); ex.push_back(CLEAN());
        st.push_back(ROR(16'h3782));  ex.push_back(CLEAN());
        st.push_back(HOLD(16'h1BC0)); ex.push_back(mk(1,1,1,8'd1,16'h1BC1,16'h1BC0));
        st.push_back(HOLD(16'h1BC1)); ex.push_back(mk(1,0,1,8'd1,16'h1BC1,16'h1BC0));
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            want = sb.pop_front();
            got  = {synced, mismatch, fault, err_count, bad_expected, bad_actual};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL mismatch[%0d]: observed %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_saturate_clear();
        stim_t st[$]; obs_t ex[$]; obs_t want; obs_t got;
        int e;
        for (int k = 0; k < 300; k++) begin
            e = (k + 2 > 255) ? 255 : k + 2;
            st.push_back(HOLD(16'h0000));
            ex.push_back(mk(1,1,1,8'(e),16'h1BC1,16'h1BC0));
        end
        st.push_back(S(0,1,1,0,1,0,0,4'h0,16'h1234)); ex.push_back(CLEAN());
        st.push_back(HOLD(16'h1234));                 ex.push_back(CLEAN());
        st.push_back(ADD(4'h2, 16'h1234));            ex.push_back(CLEAN());
        st.push_back(HOLD(16'h1236));                 ex.push_back(CLEAN());
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            want = sb.pop_front();
            got  = {synced, mismatch, fault, err_count, bad_expected, bad_actual};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL saturate_clear[%0d]: observed %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_dut_reset();
        stim_t st[$]; obs_t ex[$]; obs_t want; obs_t got;
        st.push_back(ADD(4'h3, 16'h1236));            ex.push_back(CLEAN());
        st.push_back(DRST(16'h0001));                 ex.push_back(CLEAN());
        st.push_back(DRST(16'h0000));                 ex.push_back(CLEAN());
        st.push_back(ADD(4'h5, 16'h0001));            ex.push_back(CLEAN());
        st.push_back(HOLD(16'h0005));                 ex.push_back(CLEAN());
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            want = sb.pop_front();
            got  = {synced, mismatch, fault, err_count, bad_expected, bad_actual};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL dut_reset[%0d]: observed %h required %h", i, got, want);
            end
        end
    endtask

    task automatic test_reset_mid_fault();
        stim_t st[$]; obs_t ex[$]; obs_t want; obs_t got;
        st.push_back(HOLD(16'h0006));                 ex.push_back(mk(1,1,1,8'd1,16'h0005,16'h0006));
        st.push_back(DRST(16'h0000));                 ex.push_back(mk(1,0,1,8'd1,16'h0005,16'h0006));
        st.push_back(HOLD(16'h0000));                 ex.push_back(mk(1,0,1,8'd1,16'h0005,16'h0006));
        st.push_back(S(1,0,1,1,0,0,0,4'h0,16'h0000)); ex.push_back(IDLE());
        st.push_back(HOLD(16'h5555));                 ex.push_back(IDLE());
        st.push_back(LOAD(16'h5555));                 ex.push_back(CLEAN());
        st.push_back(HOLD(16'h3782));                 ex.push_back(CLEAN());
        st.push_back(HOLD(16'h3783));                 ex.push_back(mk(1,1,1,8'd1,16'h3782,16'h3783));
        st.push_back(S(0,1,0,0,1,0,0,4'h0,16'h7777)); ex.push_back(CLEAN());
        st.push_back(HOLD(16'h0000));                 ex.push_back(CLEAN());
        st.push_back(HOLD(16'h0000));                 ex.push_back(CLEAN());
        foreach (st[i]) begin
            apply(st[i], ex[i]);
            want = sb.pop_front();
            got  = {synced, mismatch, fault, err_count, bad_expected, bad_actual};
            n_chk++;
            if (got !== want) begin
                n_fail++;
                $display("FAIL reset_mid_fault[%0d]: observed %h required %h", i, got, want);
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        clear           = 1'b0;
        bus.dut_reset_n = 1'b1;
        bus.enable      = 1'b0;
        bus.check       = 1'b1;
        bus.mode        = 1'b0;
        bus.direction   = 1'b0;
        bus.value       = 4'h0;
        bus.count       = 16'h0000;
        @(negedge clock);
        test_reset();
        test_load();
        test_rotate();
        test_arith_wrap();
        test_mismatch();
        test_saturate_clear();
        test_dut_reset();
        test_reset_mid_fault();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
